// File: rtl/uart_tx_cmd_gy_26.sv
// 8N1 command transmitter for the GY-26 compass: sends explicit command bytes on request and
// auto-polls the module with POLL_CMD at a fixed period. All outputs are registered.
module uart_tx_cmd_gy_26 #(
    parameter int unsigned CLK_FREQ    = 50_000_000,
    parameter int unsigned BAUD        = 9600,
    parameter int unsigned POLL_CYCLES = 5_000_000,
    parameter logic [7:0]  POLL_CMD    = 8'h31
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_req,
    input  logic [7:0] cmd_code,
    input  logic       auto_en,
    output logic       tx,
    output logic       busy,
    output logic       cmd_ack,
    output logic       over_tx
);

    localparam int unsigned BPS_DIV   = CLK_FREQ / BAUD;
    localparam int unsigned BW        = (BPS_DIV > 2) ? $clog2(BPS_DIV) : 1;
    localparam int unsigned PW        = $clog2(POLL_CYCLES);
    localparam logic [BW-1:0] BAUD_LAST = BW'(BPS_DIV - 1);
    localparam logic [PW-1:0] POLL_LAST = PW'(POLL_CYCLES - 1);

    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

    state_e        state_q, state_d;
    logic [BW-1:0] baud_cnt_q, baud_cnt_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    data_q, data_d;
    logic [PW-1:0] poll_cnt_q, poll_cnt_d;
    logic          poll_pend_q, poll_pend_d;
    logic          tx_d, busy_d, cmd_ack_d, over_tx_d;

    logic accept, man_acc, poll_acc, baud_last, poll_wrap;

    // Manual requests take priority over a pending poll.
    assign accept    = (state_q == StIdle) && (cmd_req || poll_pend_q);
    assign man_acc   = (state_q == StIdle) && cmd_req;
    assign poll_acc  = accept && !cmd_req;
    assign baud_last = (baud_cnt_q == BAUD_LAST);
    assign poll_wrap = (poll_cnt_q == POLL_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= StIdle;
            baud_cnt_q  <= '0;
            bit_cnt_q   <= '0;
            data_q      <= '0;
            poll_cnt_q  <= '0;
            poll_pend_q <= 1'b0;
            tx          <= 1'b1;
            busy        <= 1'b0;
            cmd_ack     <= 1'b0;
            over_tx     <= 1'b0;
        end else begin
            state_q     <= state_d;
            baud_cnt_q  <= baud_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            data_q      <= data_d;
            poll_cnt_q  <= poll_cnt_d;
            poll_pend_q <= poll_pend_d;
            tx          <= tx_d;
            busy        <= busy_d;
            cmd_ack     <= cmd_ack_d;
            over_tx     <= over_tx_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        baud_cnt_d = baud_last ? '0 : baud_cnt_q + 1'b1;
        bit_cnt_d  = bit_cnt_q;
        data_d     = data_q;
        unique case (state_q)
            StIdle: begin
                baud_cnt_d = '0;
                bit_cnt_d  = '0;
                if (accept) begin
                    state_d = StStart;
                    data_d  = man_acc ? cmd_code : POLL_CMD;
                end
            end
            StStart: begin
                if (baud_last) state_d = StData;
            end
            StData: begin
                if (baud_last) begin
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) state_d = StStop;
                end
            end
            StStop: begin
                if (baud_last) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        // Poll counter only advances while enabled; one pending poll at most.
        poll_cnt_d  = '0;
        poll_pend_d = 1'b0;
        if (auto_en) begin
            poll_cnt_d  = poll_wrap ? '0 : poll_cnt_q + 1'b1;
            poll_pend_d = poll_pend_q;
            if (poll_acc) poll_pend_d = 1'b0;
            else if (poll_wrap) poll_pend_d = 1'b1;
        end
    end

    always_comb begin
        tx_d = 1'b1;
        unique case (state_d)
            StStart: tx_d = 1'b0;
            StData:  tx_d = data_d[bit_cnt_d];
            default: tx_d = 1'b1;
        endcase
        busy_d    = (state_d != StIdle);
        cmd_ack_d = man_acc;
        over_tx_d = (state_q == StStop) && (state_d == StIdle);
    end

endmodule

// File: tb/tb_uart_tx_cmd_gy_26.sv
// Bench for uart_tx_cmd_gy_26: directed requests push expected bytes into a queue, and a serial
// decoder on tx pops and compares each completed frame.
module tb_uart_tx_cmd_gy_26;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       cmd_req = 1'b0;
    logic [7:0] cmd_code = 8'h00;
    logic       auto_en = 1'b0;
    logic       tx, busy, cmd_ack, over_tx;

    uart_tx_cmd_gy_26 #(
        .CLK_FREQ   (160),
        .BAUD       (10),
        .POLL_CYCLES(400),
        .POLL_CMD   (8'h31)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .cmd_req (cmd_req),
        .cmd_code(cmd_code),
        .auto_en (auto_en),
        .tx      (tx),
        .busy    (busy),
        .cmd_ack (cmd_ack),
        .over_tx (over_tx)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass = 0;
    int cyc = 0;
    int ack_cnt = 0;
    int over_cnt = 0;
    int busy_hi = 0;
    int frames_done = 0;
    logic [7:0] exp_q[$];
    int falls[$];

    task automatic check(input string name, input int act, input int req);
        n_checks++;
        if (act == req) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, req);
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Serial decoder: samples mid-bit relative to the detected start edge.
    initial begin
        bit         in_frame = 1'b0;
        int         pos = 0;
        logic       prev_tx = 1'b1;
        logic [7:0] sh = 8'h00;
        forever begin
            @(negedge clk);
            if (cmd_ack) ack_cnt++;
            if (over_tx) over_cnt++;
            if (busy) busy_hi++;
            if (!rst) begin
                in_frame = 1'b0;
            end else if (!in_frame) begin
                if (prev_tx && !tx) begin
                    in_frame = 1'b1;
                    pos = 0;
                    falls.push_back(cyc);
                end
            end else begin
                pos++;
                if (pos == 8) begin
                    check("start_bit", int'(tx), 0);
                end else if (pos > 8 && pos < 152 && (pos - 8) % 16 == 0) begin
                    sh[(pos - 8) / 16 - 1] = tx;
                end else if (pos == 152) begin
                    check("stop_bit", int'(tx), 1);
                    in_frame = 1'b0;
                    frames_done++;
                    check("frame_expected", int'(exp_q.size() > 0), 1);
                    if (exp_q.size() > 0) check("frame_byte", int'(sh), int'(exp_q.pop_front()));
                end
            end
            prev_tx = tx;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse(input logic [7:0] code);
        cmd_code = code;
        cmd_req  = 1'b1;
        @(posedge clk);
        #1;
        cmd_req  = 1'b0;
    endtask

    task automatic wait_idle(input int bound);
        int n = 0;
        while (busy && n < bound) begin
            tick(1);
            n++;
        end
        check("idle_timeout", int'(busy), 0);
    endtask

    task automatic wait_falls(input int target, input int bound);
        int n = 0;
        while (falls.size() < target && n < bound) begin
            tick(1);
            n++;
        end
        check("frames_started", falls.size(), target);
    endtask

    initial begin
        int a0, o0, d0, f0, b0, ce, n;

        // Reset held with cmd_req asserted
        cmd_req  = 1'b1;
        cmd_code = 8'hC0;
        repeat (3) begin
            @(negedge clk);
            check("rst_tx", int'(tx), 1);
            check("rst_busy", int'(busy), 0);
            check("rst_ack", int'(cmd_ack), 0);
            check("rst_over", int'(over_tx), 0);
        end
        @(posedge clk);
        #1;
        cmd_req = 1'b0;
        rst     = 1'b1;
        tick(8);
        check("post_rst_tx", int'(tx), 1);
        check("post_rst_busy", int'(busy), 0);
        check("post_rst_ack_cnt", ack_cnt, 0);
        check("post_rst_frames", falls.size(), 0);

        // Single manual frame 0x31
        a0 = ack_cnt; o0 = over_cnt; d0 = frames_done;
        exp_q.push_back(8'h31);
        pulse(8'h31);
        check("ack_pulse", int'(cmd_ack), 1);
        check("busy_rise", int'(busy), 1);
        check("tx_start", int'(tx), 0);
        n = 0;
        while (busy && n < 400) begin
            tick(1);
            n++;
        end
        check("busy_len", n, 160);
        check("over_at_fall", int'(over_tx), 1);
        tick(1);
        check("over_one_cycle", int'(over_tx), 0);
        check("ack_count_t2", ack_cnt - a0, 1);
        check("over_count_t2", over_cnt - o0, 1);
        check("frames_t2", frames_done - d0, 1);

        // Request mid-frame is ignored
        tick(3);
        a0 = ack_cnt; o0 = over_cnt; d0 = frames_done; f0 = falls.size();
        exp_q.push_back(8'h31);
        pulse(8'h31);
        tick(39);
        pulse(8'hC0);
        check("busy_ack_ignored", int'(cmd_ack), 0);
        wait_idle(400);
        tick(20);
        check("ack_count_t3", ack_cnt - a0, 1);
        check("over_count_t3", over_cnt - o0, 1);
        check("frames_t3", frames_done - d0, 1);
        check("falls_t3", falls.size() - f0, 1);

        // Auto-poll period
        f0 = falls.size();
        ce = cyc;
        auto_en = 1'b1;
        repeat (3) exp_q.push_back(8'h31);
        wait_falls(f0 + 3, 1500);
        auto_en = 1'b0;
        if (falls.size() >= f0 + 3) begin
            check("poll_first", falls[f0] - ce, 401);
            check("poll_period1", falls[f0 + 1] - falls[f0], 400);
            check("poll_period2", falls[f0 + 2] - falls[f0 + 1], 400);
        end
        wait_idle(400);
        tick(500);
        check("poll_stopped", falls.size() - f0, 3);
        check("queue_empty_t4", exp_q.size(), 0);

        // Manual command coinciding with a pending poll
        ce = cyc;
        auto_en = 1'b1;
        tick(400);
        f0 = falls.size(); b0 = busy_hi; a0 = ack_cnt; o0 = over_cnt;
        exp_q.push_back(8'hC1);
        exp_q.push_back(8'h31);
        pulse(8'hC1);
        check("ack_coincide", int'(cmd_ack), 1);
        wait_falls(f0 + 2, 600);
        auto_en = 1'b0;
        wait_idle(400);
        tick(2);
        if (falls.size() >= f0 + 2) begin
            check("coincide_first", falls[f0] - ce, 401);
            check("back_to_back", falls[f0 + 1] - falls[f0], 161);
        end
        check("busy_total_t5", busy_hi - b0, 320);
        check("over_count_t5", over_cnt - o0, 2);
        check("ack_count_t5", ack_cnt - a0, 1);
        check("queue_empty_t5", exp_q.size(), 0);

        // Reset mid-frame, then a clean frame
        tick(5);
        o0 = over_cnt; d0 = frames_done;
        pulse(8'h5A);
        tick(69);
        rst = 1'b0;
        #1;
        check("abort_tx", int'(tx), 1);
        check("abort_busy", int'(busy), 0);
        tick(2);
        rst = 1'b1;
        tick(3);
        check("abort_idle_tx", int'(tx), 1);
        check("abort_idle_busy", int'(busy), 0);
        exp_q.push_back(8'hA5);
        pulse(8'hA5);
        wait_idle(400);
        tick(3);
        check("frames_t6", frames_done - d0, 1);
        check("over_count_t6", over_cnt - o0, 1);
        check("queue_empty_t6", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
